bcd_seg_scan: RTL and testbench
===============================

Name: bcd_seg_scan

Overview:
Time-multiplexed 7-segment display driver. It sits directly downstream of the combinational binary-to-BCD converter and consumes its packed 8-digit BCD word. The word is captured on a load strobe and applied only at frame boundaries, so the display never tears. The block then scans one digit at a time onto active-low common-anode outputs at a programmable refresh rate.

Parameters:
NUM_DIGITS, 8, number of BCD digits and anode lines.
BCD_WIDTH, 32, packed BCD input width; must equal 4*NUM_DIGITS.
REFRESH_DIV, 100000, clocks per digit slot (100 MHz gives 1 kHz per digit); must be ≥2.
IDX_W, 3, width of the digit index; must satisfy 2**IDX_W ≥ NUM_DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
bcd_in  input  BCD_WIDTH  packed BCD digits; digit k = bcd_in[4k+3:4k]; digit 0 is rightmost.
bcd_valid  input  1  one-cycle load strobe qualifying bcd_in.
dp_in  input  NUM_DIGITS  decimal-point enables, bit k for digit k, active-high; sampled live (not latched).
blank  input  1  forces all anodes off while high.
an  output  NUM_DIGITS  anode enables, active-low, registered.
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
dp  output  1  decimal-point cathode, active-low, registered.
digit_idx  output  IDX_W  index of the digit currently being driven.
frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (async, rst_n low): prescaler=0, digit_idx=0, disp_reg=0, pend_reg=0, pend_flag=0, an=all 1, seg=7'h7F, dp=1, frame_done=0.
- Prescaler counts 0..REFRESH_DIV-1. tick is asserted in the cycle where prescaler==REFRESH_DIV-1; the prescaler then wraps to 0.
- On tick, digit_idx advances by 1 modulo NUM_DIGITS. On the wrap to 0, frame_done=1 for exactly that cycle.
- Load handshake: when bcd_valid=1, pend_reg<=bcd_in and pend_flag<=1. A later strobe before the frame boundary overwrites the pending value; the last one wins.
- Frame swap: on a wrap tick, if bcd_valid=1 in the same cycle, disp_reg<=bcd_in directly and pend_flag<=0. Otherwise, if pend_flag=1, disp_reg<=pend_reg and pend_flag<=0. Otherwise disp_reg holds.
- Output stage (registered, one cycle behind digit_idx and disp_reg):
  - an = all 1 except bit digit_idx = 0.
  - seg = decode of disp_reg nibble[digit_idx].
  - dp = ~dp_in[digit_idx].
- Decode table (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles A–F are illegal BCD and display a dash, 3F.
- blank=1: an=all 1 on the next clock. Scan, prescaler and load logic keep running. seg and dp still follow the decode.
- Reset mid-scan: all state clears immediately. Any pending value is discarded and the display shows 0 in digit 0 after release.
- The first output-register update after reset release shows digit 0 with "0": an=FE, seg=40.

Optional Feature:
- Macro: BCD_SEG_LZB_EN (leading-zero blanking).
- Defined: a digit k>0 has its anode held high whenever digit k and every digit above it are 0 in disp_reg. Digit 0 is always lit, so value 0 shows a single "0". Blanking is computed from disp_reg combinationally and registered with an.
- Undefined: all NUM_DIGITS digits are always lit, and zeros are shown.

Test Plan (REFRESH_DIV=4 for simulation):
- Reset, then release and run 40 clocks -> digit_idx walks 0..7 with 4 clocks per digit; frame_done pulses once per 32 clocks; an cycles FE,FD,…,7F; seg=40 on every digit.
- bcd_valid with bcd_in=32'h01234567 mid-frame -> display stays all zeros until the wrap; next frame shows seg 78,02,12,19,30,24,79,40 on digits 0..7.
- Two strobes in one frame (32'h11111111, then 32'h22222222), plus a third strobe 32'h99999999 in the wrap cycle -> next frame shows only 9 (seg=10) on all digits; pend_flag=0 afterward.
- bcd_in=32'h0000A00F -> digits 0 and 3 show 3F; the other digits show 40 (without LZB).
- With BCD_SEG_LZB_EN, bcd_in=32'h00000305 -> an is asserted only for digits 0..2 (seg 12,40,30); digits 3..7 stay dark; bcd_in=0 -> only digit 0 lit, seg=40.
- blank=1 for 10 clocks mid-scan, then drop rst_n mid-digit -> an=FF during blank while digit_idx keeps advancing; on reset, an=FF, seg=7F, dp=1 immediately, and disp_reg returns to 0.

Source files
------------

// File: rtl/bcd_seg_scan_if.sv
// Signal bundle between the BCD source/display control and the scanned 7-segment driver.
interface bcd_seg_scan_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BCD_WIDTH  = 32,
  parameter int IDX_W      = 3
);
  logic [BCD_WIDTH-1:0]  bcd_in;
  logic                  bcd_valid;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;

  modport master (
    output bcd_in, bcd_valid, dp_in, blank,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  bcd_in, bcd_valid, dp_in, blank,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed active-low 7-segment scanner with tear-free frame-boundary loading.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int BCD_WIDTH   = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = 3
) (
  input logic          clk,
  input logic          rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_WIDTH-1:0]  disp_q, disp_d;
  logic [BCD_WIDTH-1:0]  pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;
  logic                  tick, wrap;
  logic [NUM_DIGITS-1:0] lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

`ifdef BCD_SEG_LZB_EN
  // A digit stays lit if it or any digit above it is nonzero; digit 0 always lit.
  always_comb begin
    lit    = '1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lit[k] = ((disp_q >> (4 * k)) != '0);
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    tick        = (presc_q == PW'(REFRESH_DIV - 1));
    wrap        = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    fd_d        = wrap;

    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (bus.bcd_valid) begin
      pend_d      = bus.bcd_in;
      pend_flag_d = 1'b1;
    end
    // A strobe coinciding with the wrap bypasses the pending register.
    if (wrap) begin
      if (bus.bcd_valid) begin
        disp_d = bus.bcd_in;
      end else if (pend_flag_q) begin
        disp_d = pend_q;
      end
      pend_flag_d = 1'b0;
    end

    an_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!bus.blank && (idx_q == IDX_W'(k)) && lit[k]) begin
        an_d[k] = 1'b0;
      end
    end
    seg_d = seg_decode(disp_q[4 * idx_q +: 4]);
    dp_d  = ~bus.dp_in[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized bench for bcd_seg_scan, checked against a cycle-count based reference model.
module tb_bcd_seg_scan;

  localparam int N     = 8;
  localparam int W     = 32;
  localparam int DIV   = 4;
  localparam int IW    = 3;
  localparam int FRAME = DIV * N;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  bcd_seg_scan_if #(.NUM_DIGITS(N), .BCD_WIDTH(W), .IDX_W(IW)) bus ();

  bcd_seg_scan #(.NUM_DIGITS(N), .BCD_WIDTH(W), .REFRESH_DIV(DIV), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model: time since reset determines the digit; words follow the last-strobe-wins rule.
  int          m_t       = 0;
  logic [31:0] m_disp    = '0;
  logic [31:0] m_pend    = '0;
  bit          m_pflag   = 1'b0;
  logic [7:0]  e_an      = 8'hFF;
  logic [6:0]  e_seg     = 7'h7F;
  logic        e_dp      = 1'b1;
  logic        e_fd      = 1'b0;

  function automatic bit digit_lit(input logic [31:0] word, input int k);
`ifdef BCD_SEG_LZB_EN
    return (k == 0) || ((word >> (4 * k)) != 0);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pflag = 1'b0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      int  cur;
      bit  wrap;
      cur  = (m_t / DIV) % N;
      wrap = (m_t % FRAME) == FRAME - 1;
      e_an = 8'hFF;
      if (!bus.blank && digit_lit(m_disp, cur)) e_an[cur] = 1'b0;
      e_seg = dec_t[(m_disp >> (4 * cur)) & 32'hF];
      e_dp  = ~bus.dp_in[cur];
      e_fd  = wrap;
      if (wrap) begin
        if (bus.bcd_valid) m_disp = bus.bcd_in;
        else if (m_pflag) m_disp = m_pend;
        m_pflag = 1'b0;
      end else if (bus.bcd_valid) begin
        m_pend  = bus.bcd_in;
        m_pflag = 1'b1;
      end
      m_t++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("an",         32'(bus.an),         32'(e_an));
      check("seg",        32'(bus.seg),        32'(e_seg));
      check("dp",         32'(bus.dp),         32'(e_dp));
      check("frame_done", 32'(bus.frame_done), 32'(e_fd));
      check("digit_idx",  32'(bus.digit_idx),  32'((m_t / DIV) % N));
    end
  end

  task automatic strobe(input logic [31:0] w);
    bus.bcd_in    = w;
    bus.bcd_valid = 1'b1;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
  endtask

  // Park at the negedge just before the wrap edge (bounded search).
  task automatic to_wrap_cycle();
    int guard = 0;
    while ((m_t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2 * FRAME) check("wrap_timeout", 32'(guard), 32'(0));
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an",  32'(bus.an),        32'hFF);
    check("rst_seg", 32'(bus.seg),       32'h7F);
    check("rst_dp",  32'(bus.dp),        32'h1);
    check("rst_idx", 32'(bus.digit_idx), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.bcd_in = '0; bus.bcd_valid = 1'b0; bus.dp_in = '0; bus.blank = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an",  32'(bus.an),  32'hFE);
    check("first_seg", 32'(bus.seg), 32'h40);
    repeat (40) @(negedge clk);

    // Mid-frame load appears only after the wrap.
    repeat (5) @(negedge clk);
    strobe(32'h01234567);
    repeat (2 * FRAME) @(negedge clk);

    // Two strobes in one frame, third in the wrap cycle wins.
    strobe(32'h11111111);
    repeat (3) @(negedge clk);
    strobe(32'h22222222);
    to_wrap_cycle();
    strobe(32'h99999999);
    repeat (2 * FRAME) @(negedge clk);

    // Illegal nibbles, then leading-zero cases, with varied decimal points.
    bus.dp_in = 8'hA5;
    strobe(32'h0000A00F);
    repeat (2 * FRAME) @(negedge clk);
    strobe(32'h00000305);
    repeat (2 * FRAME) @(negedge clk);
    strobe(32'h00000000);
    repeat (2 * FRAME) @(negedge clk);

    // Blank mid-scan, then reset mid-digit with a load still pending.
    strobe(32'h87654321);
    repeat (2 * FRAME + 6) @(negedge clk);
    bus.blank = 1'b1;
    repeat (10) @(negedge clk);
    bus.blank = 1'b0;
    strobe(32'h55555555);
    mid_reset();
    repeat (2 * FRAME) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < N; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) w = w >> (4 * $urandom_range(1, 7));
      end
      bus.bcd_in    = w;
      bus.bcd_valid = ($urandom_range(0, 11) == 0);
      bus.dp_in     = 8'($urandom);
      bus.blank     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        bus.bcd_valid = 1'b0;
        mid_reset();
      end else begin
        @(negedge clk);
      end
    end
    bus.bcd_valid = 1'b0;
    bus.blank     = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
